// File: rtl/rv_decode_pkg.sv
// Shared opcodes, control codes and the decoded-control bundle for the RV32I decode stage.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  localparam logic [2:0] M2R_ALU   = 3'b000;
  localparam logic [2:0] M2R_MEM   = 3'b001;
  localparam logic [2:0] M2R_PC4   = 3'b010;
  localparam logic [2:0] M2R_IMM   = 3'b011;
  localparam logic [2:0] M2R_PCIMM = 3'b100;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Immediate is carried beside this bundle because its width follows XLEN.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_ctr;
    logic       alu_b_ctr;
    logic [3:0] bxx;
    logic       jal;
    logic       jalr;
    logic       reg_we;
    logic       mem_we;
    logic [2:0] mem2reg;
    logic [2:0] data_mem_opr;
    logic [3:0] data_mem_opw;
    logic       md;
    logic       illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface rv_decode_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [3:0]      out_alu_ctr;
  logic            out_alu_b_ctr;
  logic [3:0]      out_bxx;
  logic            out_jal;
  logic            out_jalr;
  logic            out_reg_we;
  logic            out_mem_we;
  logic [2:0]      out_mem2reg;
  logic [2:0]      out_data_mem_opr;
  logic [3:0]      out_data_mem_opw;
  logic            out_md;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_alu_ctr, out_alu_b_ctr, out_bxx, out_jal, out_jalr, out_reg_we,
           out_mem_we, out_mem2reg, out_data_mem_opr, out_data_mem_opw, out_md, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_alu_ctr, out_alu_b_ctr, out_bxx, out_jal, out_jalr, out_reg_we,
           out_mem_we, out_mem2reg, out_data_mem_opr, out_data_mem_opw, out_md, out_illegal
  );
endinterface

// File: rtl/rv_decode_comb.sv
// Combinational RV32I decoder: instruction word to control bundle plus immediate.
// Define RV_DECODE_M_EXT_EN to decode the M-extension (funct7=0000001 on OP).
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output dec_ctrl_t       o_ctrl,
  output logic [XLEN-1:0] o_imm
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic w_ill, w_branch, w_jal, w_jalr, w_reg_we, w_mem_we, w_md, w_alu_b;
  logic [3:0] w_alu, w_opw;
  logic [2:0] w_m2r, w_opr;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];

  assign w_imm_i = XLEN'($signed(i_instr[31:20]));
  assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));

  always_comb begin
    w_ill = 1'b0; w_branch = 1'b0; w_jal = 1'b0; w_jalr = 1'b0;
    w_reg_we = 1'b0; w_mem_we = 1'b0; w_md = 1'b0; w_alu_b = 1'b0;
    w_alu = ALU_ADD; w_m2r = M2R_ALU; w_opr = 3'b000; w_opw = 4'b0000;
    o_imm = '0;
    case (w_opc)
      OPC_REG: begin
        w_reg_we = 1'b1;
        if (w_f7 == 7'b0000000) w_alu = {1'b0, w_f3};
        else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) w_alu = {1'b1, w_f3};
`ifdef RV_DECODE_M_EXT_EN
        else if (w_f7 == 7'b0000001) w_md = 1'b1;
`endif
        else w_ill = 1'b1;
      end
      OPC_IMM: begin
        w_reg_we = 1'b1; w_alu_b = 1'b1; o_imm = w_imm_i;
        w_alu = {1'b0, w_f3};
        if (w_f3 == 3'b001) w_ill = (w_f7 != 7'b0000000);
        else if (w_f3 == 3'b101) begin
          w_alu[3] = i_instr[30];
          w_ill = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
        end
      end
      OPC_LOAD: begin
        w_reg_we = 1'b1; w_alu_b = 1'b1; o_imm = w_imm_i; w_m2r = M2R_MEM; w_opr = w_f3;
        w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_mem_we = 1'b1; w_alu_b = 1'b1; o_imm = w_imm_s; w_opr = w_f3;
        case (w_f3)
          3'b000:  w_opw = MASK_BYTE;
          3'b001:  w_opw = MASK_HALF;
          3'b010:  w_opw = MASK_WORD;
          default: w_ill = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        w_branch = 1'b1; o_imm = w_imm_b;
        case (w_f3[2:1])
          2'b00:   w_alu = ALU_SUB;
          2'b10:   w_alu = ALU_SLT;
          2'b11:   w_alu = ALU_SLTU;
          default: w_ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        w_jal = 1'b1; w_reg_we = 1'b1; w_alu_b = 1'b1; o_imm = w_imm_j; w_m2r = M2R_PC4;
      end
      OPC_JALR: begin
        w_jalr = 1'b1; w_reg_we = 1'b1; w_alu_b = 1'b1; o_imm = w_imm_i; w_m2r = M2R_PC4;
        w_ill = (w_f3 != 3'b000);
      end
      OPC_LUI: begin
        w_reg_we = 1'b1; w_alu_b = 1'b1; o_imm = w_imm_u; w_m2r = M2R_IMM;
      end
      OPC_AUIPC: begin
        w_reg_we = 1'b1; w_alu_b = 1'b1; o_imm = w_imm_u; w_m2r = M2R_PCIMM;
      end
      default: w_ill = 1'b1;
    endcase
  end

  // An illegal bundle still flows, but must never write state or redirect control.
  always_comb begin
    o_ctrl              = '0;
    o_ctrl.rs1          = i_instr[19:15];
    o_ctrl.rs2          = i_instr[24:20];
    o_ctrl.reg_we       = w_reg_we & ~w_ill;
    o_ctrl.rd           = o_ctrl.reg_we ? i_instr[11:7] : 5'd0;
    o_ctrl.alu_ctr      = w_alu;
    o_ctrl.alu_b_ctr    = w_alu_b;
    o_ctrl.bxx          = {w_branch & ~w_ill, w_f3};
    o_ctrl.jal          = w_jal & ~w_ill;
    o_ctrl.jalr         = w_jalr & ~w_ill;
    o_ctrl.mem_we       = w_mem_we & ~w_ill;
    o_ctrl.mem2reg      = w_m2r;
    o_ctrl.data_mem_opr = w_opr;
    o_ctrl.data_mem_opw = w_opw;
    o_ctrl.md           = w_md & ~w_ill;
    o_ctrl.illegal      = w_ill;
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: main + skid bundle registers with valid/ready flow control.
// Optional M-extension decode is enabled by defining RV_DECODE_M_EXT_EN.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  rv_decode_if.slave  io_dec
);

  dec_ctrl_t       w_dec_ctrl;
  logic [XLEN-1:0] w_dec_imm;

  dec_ctrl_t       r_main_ctrl, r_skid_ctrl;
  logic [XLEN-1:0] r_main_imm, r_skid_imm, r_main_pc, r_skid_pc;
  logic            r_main_valid, r_skid_valid, r_in_ready;

  logic w_accept, w_main_free, w_skid_valid_next;

  rv_decode_comb #(.XLEN(XLEN)) u_comb (
    .i_instr (io_dec.in_instr),
    .o_ctrl  (w_dec_ctrl),
    .o_imm   (w_dec_imm)
  );

  // in_ready is registered, so out_ready never reaches the fetch side combinationally.
  assign w_accept          = io_dec.in_valid & r_in_ready & ~flush;
  assign w_main_free       = ~r_main_valid | io_dec.out_ready;
  assign w_skid_valid_next = ~flush & ~w_main_free & (r_skid_valid | w_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_imm   <= '0;
      r_main_pc    <= PC_RESET;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_imm   <= '0;
      r_skid_pc    <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_in_ready   <= ~w_skid_valid_next;
      r_skid_valid <= w_skid_valid_next;
      if (flush) begin
        r_main_valid <= 1'b0;
      end else if (w_main_free) begin
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_ctrl  <= r_skid_ctrl;
          r_main_imm   <= r_skid_imm;
          r_main_pc    <= r_skid_pc;
        end else begin
          r_main_valid <= w_accept;
          if (w_accept) begin
            r_main_ctrl <= w_dec_ctrl;
            r_main_imm  <= w_dec_imm;
            r_main_pc   <= io_dec.in_pc;
          end
        end
      end
      // Main is stalled: the newly accepted bundle parks in the skid entry.
      if (!flush && !w_main_free && w_accept) begin
        r_skid_ctrl <= w_dec_ctrl;
        r_skid_imm  <= w_dec_imm;
        r_skid_pc   <= io_dec.in_pc;
      end
    end
  end

  assign io_dec.in_ready         = r_in_ready;
  assign io_dec.out_valid        = r_main_valid;
  assign io_dec.out_pc           = r_main_pc;
  assign io_dec.out_imm          = r_main_imm;
  assign io_dec.out_rs1          = r_main_ctrl.rs1;
  assign io_dec.out_rs2          = r_main_ctrl.rs2;
  assign io_dec.out_rd           = r_main_ctrl.rd;
  assign io_dec.out_alu_ctr      = r_main_ctrl.alu_ctr;
  assign io_dec.out_alu_b_ctr    = r_main_ctrl.alu_b_ctr;
  assign io_dec.out_bxx          = r_main_ctrl.bxx;
  assign io_dec.out_jal          = r_main_ctrl.jal;
  assign io_dec.out_jalr         = r_main_ctrl.jalr;
  assign io_dec.out_reg_we       = r_main_ctrl.reg_we;
  assign io_dec.out_mem_we       = r_main_ctrl.mem_we;
  assign io_dec.out_mem2reg      = r_main_ctrl.mem2reg;
  assign io_dec.out_data_mem_opr = r_main_ctrl.data_mem_opr;
  assign io_dec.out_data_mem_opw = r_main_ctrl.data_mem_opw;
  assign io_dec.out_md           = r_main_ctrl.md;
  assign io_dec.out_illegal      = r_main_ctrl.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed scoreboard bench for rv_decode_stage; honours RV_DECODE_M_EXT_EN for the mul case.
module tb_rv_decode_stage;

  localparam logic [31:0] PC_RST = 32'h0000_0100;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        full;
    logic        chk_rs;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        alu_b;
    logic [3:0]  bxx;
    logic        jal, jalr, reg_we, mem_we;
    logic [2:0]  m2r, opr;
    logic [3:0]  opw;
    logic        md, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  rv_decode_if #(.XLEN(32)) dec_if ();

  rv_decode_stage #(.XLEN(32), .PC_RESET(PC_RST)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .io_dec (dec_if)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  exp_t        m_e;
  int          tests = 0;
  int          fails = 0;
  int          n_pushed = 0;
  int          n_out = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t base(input string tag, input logic [31:0] instr);
    exp_t e;
    e.tag = tag; e.instr = instr; e.pc = '0; e.full = 1'b1; e.chk_rs = 1'b0;
    e.imm = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.alu = '0; e.alu_b = 1'b0;
    e.bxx = '0; e.jal = 1'b0; e.jalr = 1'b0; e.reg_we = 1'b0; e.mem_we = 1'b0;
    e.m2r = '0; e.opr = '0; e.opw = '0; e.md = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  task automatic send(input exp_t e);
    int n = 0;
    bit took = 1'b0;
    e.pc = pc_ctr;
    pc_ctr += 32'd4;
    dec_if.in_valid = 1'b1;
    dec_if.in_instr = e.instr;
    dec_if.in_pc    = e.pc;
    while (!took && n < 50) begin
      @(negedge clk);
      took = dec_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    dec_if.in_valid = 1'b0;
    chk({e.tag, "_accept"}, 64'(took), 64'd1);
    if (took) begin
      sb.push_back(e);
      n_pushed++;
      $display("[TB] in  %-8s pc=%h instr=%h", e.tag, e.pc, e.instr);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic discard();
    n_pushed -= sb.size();
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && dec_if.out_valid && dec_if.out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        m_e = sb.pop_front();
        n_out++;
        $display("[TB] out %-8s pc=%h imm=%h rd=%0d illegal=%0b", m_e.tag, dec_if.out_pc,
                 dec_if.out_imm, dec_if.out_rd, dec_if.out_illegal);
        chk({m_e.tag, "_ctl"},
            64'({dec_if.out_pc, dec_if.out_rd, dec_if.out_jal, dec_if.out_jalr, dec_if.out_reg_we,
                 dec_if.out_mem_we, dec_if.out_bxx[3], dec_if.out_md, dec_if.out_illegal}),
            64'({m_e.pc, m_e.rd, m_e.jal, m_e.jalr, m_e.reg_we, m_e.mem_we, m_e.bxx[3], m_e.md, m_e.ill}));
        if (m_e.full)
          chk({m_e.tag, "_dat"},
              64'({dec_if.out_imm, dec_if.out_alu_ctr, dec_if.out_alu_b_ctr, dec_if.out_bxx[2:0],
                   dec_if.out_mem2reg, dec_if.out_data_mem_opr, dec_if.out_data_mem_opw}),
              64'({m_e.imm, m_e.alu, m_e.alu_b, m_e.bxx[2:0], m_e.m2r, m_e.opr, m_e.opw}));
        if (m_e.chk_rs)
          chk({m_e.tag, "_rs"}, 64'({dec_if.out_rs1, dec_if.out_rs2}), 64'({m_e.rs1, m_e.rs2}));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [31:0] pc_a;

    rst_n = 1'b0; flush = 1'b0;
    dec_if.in_valid = 1'b0; dec_if.in_instr = '0; dec_if.in_pc = '0; dec_if.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(dec_if.out_valid), 64'd0);
    chk("rst_out_pc", 64'(dec_if.out_pc), 64'(PC_RST));
    chk("rst_out_imm", 64'(dec_if.out_imm), 64'd0);
    chk("rst_ctl", 64'({dec_if.out_reg_we, dec_if.out_rd, dec_if.out_alu_ctr, dec_if.out_illegal}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(dec_if.in_ready), 64'd1);

    // single addi, one-cycle latency
    e = base("addi", 32'h0050_0093);
    e.imm = 32'd5; e.rd = 5'd1; e.alu_b = 1'b1; e.reg_we = 1'b1;
    send(e);
    chk("addi_latency_valid", 64'(dec_if.out_valid), 64'd1);
    drain();

    // back-to-back stream at full throughput
    e = base("sub", 32'h4020_81B3);
    e.chk_rs = 1'b1; e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd3; e.alu = 4'b1000; e.reg_we = 1'b1;
    send(e);
    e = base("beq", 32'h0020_8463);
    e.chk_rs = 1'b1; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd8; e.alu = 4'b1000; e.bxx = 4'b1000;
    send(e);
    e = base("blt", 32'hFE20_CEE3);
    e.chk_rs = 1'b1; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'hFFFF_FFFC; e.alu = 4'b0010; e.bxx = 4'b1100;
    send(e);
    e = base("lui", 32'h1234_53B7);
    e.imm = 32'h1234_5000; e.rd = 5'd7; e.alu_b = 1'b1; e.reg_we = 1'b1; e.m2r = 3'b011; e.bxx = 4'b0101;
    send(e);
    e = base("srai", 32'h4030_D093);
    e.imm = 32'h0000_0403; e.rd = 5'd1; e.alu = 4'b1101; e.alu_b = 1'b1; e.reg_we = 1'b1; e.bxx = 4'b0101;
    send(e);
    e = base("sw", 32'h0020_A623);
    e.chk_rs = 1'b1; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd12; e.alu_b = 1'b1; e.bxx = 4'b0010;
    e.mem_we = 1'b1; e.opr = 3'b010; e.opw = 4'b1111;
    send(e);
    drain();

    // back-pressure: two fill main+skid, third held until release
    dec_if.out_ready = 1'b0;
    e = base("addi_m1", 32'hFFF0_0113);
    e.imm = 32'hFFFF_FFFF; e.rd = 5'd2; e.alu_b = 1'b1; e.reg_we = 1'b1;
    pc_a = pc_ctr;
    send(e);
    e = base("lw", 32'h0080_A283);
    e.imm = 32'd8; e.rd = 5'd5; e.alu_b = 1'b1; e.reg_we = 1'b1; e.m2r = 3'b001; e.opr = 3'b010;
    e.bxx = 4'b0010;
    send(e);
    chk("bp_in_ready_low", 64'(dec_if.in_ready), 64'd0);
    e = base("addi_bp", 32'h0050_0093);
    e.imm = 32'd5; e.rd = 5'd1; e.alu_b = 1'b1; e.reg_we = 1'b1;
    fork
      send(e);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_pc", 64'(dec_if.out_pc), 64'(pc_a));
        chk("bp_hold_in_ready", 64'(dec_if.in_ready), 64'd0);
        dec_if.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(n_out), 64'(n_pushed));

    // flush with main and skid full, instruction offered in the same cycle
    dec_if.out_ready = 1'b0;
    send(base("fl_a", 32'h0050_0093));
    send(base("fl_b", 32'h0050_0093));
    dec_if.in_valid = 1'b1; dec_if.in_instr = 32'h0050_0093; dec_if.in_pc = 32'hDEAD_0000;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; dec_if.in_valid = 1'b0;
    discard();
    chk("flush_full_out_valid", 64'(dec_if.out_valid), 64'd0);
    chk("flush_full_in_ready", 64'(dec_if.in_ready), 64'd1);

    // flush wins over a simultaneous accept
    send(base("fl_c", 32'h0050_0093));
    dec_if.in_valid = 1'b1; dec_if.in_instr = 32'h0050_0093; dec_if.in_pc = 32'hDEAD_0004;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; dec_if.in_valid = 1'b0;
    discard();
    chk("flush_accept_out_valid", 64'(dec_if.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_accept_discarded", 64'(dec_if.out_valid), 64'd0);
    dec_if.out_ready = 1'b1;

    // illegal / JAL / mul / illegal shift after the flush
    e = base("ones", 32'hFFFF_FFFF);
    e.full = 1'b0; e.ill = 1'b1;
    send(e);
    e = base("jal", 32'h0000_306F);
    e.full = 1'b0; e.jal = 1'b1; e.reg_we = 1'b1;
    send(e);
    e = base("mul", 32'h0220_81B3);
    e.full = 1'b0;
`ifdef RV_DECODE_M_EXT_EN
    e.md = 1'b1; e.reg_we = 1'b1; e.rd = 5'd3;
`else
    e.ill = 1'b1;
`endif
    send(e);
    e = base("slli_bad", 32'h4000_9093);
    e.full = 1'b0; e.ill = 1'b1;
    send(e);
    drain();

    // asynchronous reset in the middle of a stalled transfer
    dec_if.out_ready = 1'b0;
    send(base("ar_a", 32'h0050_0093));
    chk("ar_pre_valid", 64'(dec_if.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(dec_if.out_valid), 64'd0);
    chk("ar_out_pc", 64'(dec_if.out_pc), 64'(PC_RST));
    discard();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_in_ready", 64'(dec_if.in_ready), 64'd1);
    dec_if.out_ready = 1'b1;
    e = base("addi_end", 32'h0050_0093);
    e.imm = 32'd5; e.rd = 5'd1; e.alu_b = 1'b1; e.reg_we = 1'b1;
    send(e);
    drain();
    chk("final_count", 64'(n_out), 64'(n_pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
